// File: rtl/iter_mul_div_if.sv
// Control/write-back bundle between the decode stage, the iterative mul/div unit and the register file.
interface iter_mul_div_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic [2:0]            op;
  logic [XLEN-1:0]       operand_a;
  logic [XLEN-1:0]       operand_b;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic                  busy;
  logic                  done;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [XLEN-1:0]       write_data;
  logic                  regwrite;

  // Handshake: start is sampled only while busy is low; the command fields are
  // captured on that edge. While busy is high, start is dropped, not queued.
  // done pulses for exactly one cycle, with write_reg and write_data valid in it.
  modport master (
    output start, op, operand_a, operand_b, dest_reg,
    input  busy, done, write_reg, write_data, regwrite
  );
  modport slave (
    input  start, op, operand_a, operand_b, dest_reg,
    output busy, done, write_reg, write_data, regwrite
  );
endinterface

// File: rtl/iter_mul_div.sv
// Radix-2 iterative multiply/divide unit with fixed XLEN-cycle latency and one-cycle write-back.
// Define MULDIV_SIGNED_EN to turn ops 100/101/110 into signed MULH/DIV/REM.
module iter_mul_div #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  iter_mul_div_if.slave bus,
  output logic [1:0]    dbg_state
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d, wreg_q, wreg_d;
  logic                  is_div_q, is_div_d, sel_hi_q, sel_hi_d, zero_q, zero_d;

  logic                  acc_div, acc_hi, acc_zero;
  logic [XLEN-1:0]       mag_a, mag_b;
  logic [XLEN:0]         sum, rem_sh;
  logic                  q_bit;
  logic [XLEN-1:0]       step_hi, step_lo, quo, rem, result;
  logic [2*XLEN-1:0]     prod;

`ifdef MULDIV_SIGNED_EN
  logic neg_a, neg_b, neg_p_q, neg_p_d, neg_r_q, neg_r_d;

  always_comb begin
    acc_zero = (bus.op == 3'b111);
    acc_div  = (bus.op == 3'b010) || (bus.op == 3'b011) || (bus.op == 3'b101) || (bus.op == 3'b110);
    acc_hi   = (bus.op == 3'b001) || (bus.op == 3'b011) || (bus.op == 3'b100) || (bus.op == 3'b110);
    neg_a    = bus.op[2] && !acc_zero && bus.operand_a[XLEN-1];
    neg_b    = bus.op[2] && !acc_zero && bus.operand_b[XLEN-1];
    mag_a    = neg_a ? -bus.operand_a : bus.operand_a;
    mag_b    = neg_b ? -bus.operand_b : bus.operand_b;
    // A zero divisor must keep the all-ones quotient, so never negate it.
    neg_p_d  = (neg_a ^ neg_b) && (bus.operand_b != '0);
    neg_r_d  = neg_a;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  always_comb begin
    acc_zero = (bus.op == 3'b111);
    acc_div  = bus.op[1] && !acc_zero;
    acc_hi   = bus.op[0];
    mag_a    = bus.operand_a;
    mag_b    = bus.operand_b;
  end
`endif

  // One radix-2 step: {hi,lo} is the product/partial-remainder pair, lo collects quotient bits.
  always_comb begin
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh = {hi_q, lo_q[XLEN-1]};
    q_bit  = (rem_sh >= {1'b0, b_q});
    if (is_div_q) begin
      step_hi = q_bit ? XLEN'(rem_sh - {1'b0, b_q}) : XLEN'(rem_sh);
      step_lo = {lo_q[XLEN-2:0], q_bit};
    end else begin
      step_hi = sum[XLEN:1];
      step_lo = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = {step_hi, step_lo};
    quo  = step_lo;
    rem  = step_hi;
`ifdef MULDIV_SIGNED_EN
    if (neg_p_q) begin
      prod = -{step_hi, step_lo};
      quo  = -step_lo;
    end
    if (neg_r_q) rem = -step_hi;
`endif
    if (zero_q)        result = '0;
    else if (is_div_q) result = sel_hi_q ? rem : quo;
    else               result = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    dest_d   = dest_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    zero_d   = zero_q;
    wdata_d  = wdata_q;
    wreg_d   = wreg_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d  = CALC;
        cnt_d    = '0;
        hi_d     = '0;
        lo_d     = acc_div ? mag_a : mag_b;
        b_d      = acc_div ? mag_b : mag_a;
        dest_d   = bus.dest_reg;
        is_div_d = acc_div;
        sel_hi_d = acc_hi;
        zero_d   = acc_zero;
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = DONE;
          wdata_d = result;
          wreg_d  = dest_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      dest_q   <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      zero_q   <= 1'b0;
      wdata_q  <= '0;
      wreg_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      dest_q   <= dest_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
      zero_q   <= zero_d;
      wdata_q  <= wdata_d;
      wreg_q   <= wreg_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.write_reg  = wreg_q;
  assign bus.write_data = wdata_q;
  assign bus.regwrite   = (state_q == DONE) && (wreg_q != '0);
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_iter_mul_div.sv
// Bench for iter_mul_div: directed cases plus random operations against an arithmetic reference model.
module tb_iter_mul_div;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [XLEN-1:0] exp_q[$];

  iter_mul_div_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

  iter_mul_div #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    logic [63:0] ps;
    pu = {32'b0, a} * {32'b0, b};
`ifdef MULDIV_SIGNED_EN
    ps = 64'(longint'($signed(a)) * longint'($signed(b)));
    if (op == 3'b100) return ps[63:32];
    if (op == 3'b101) begin
      if (b == 32'd0) return 32'hFFFF_FFFF;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
      return 32'($signed(a) / $signed(b));
    end
    if (op == 3'b110) begin
      if (b == 32'd0) return a;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
      return 32'($signed(a) % $signed(b));
    end
`else
    ps = 64'd0;
    if (op != 3'b111) op[2] = 1'b0;
`endif
    case (op)
      3'b000:  return pu[31:0];
      3'b001:  return pu[63:32] | ps[31:0] & 32'd0;
      3'b010:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b011:  return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic scramble(input logic keep_start);
    bus.start     = keep_start;
    bus.op        = 3'($urandom);
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.dest_reg  = 5'($urandom);
  endtask

  // Called just after the accepting edge; counts edges until done (accept edge = 1).
  task automatic wait_result(input string tag, input logic [4:0] dest, input logic hold);
    int cyc;
    logic [31:0] e;
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      if (hold) scramble(1'b1);
    end
    e = exp_q.pop_front();
    check({tag, "_latency"}, 64'(cyc), 64'(XLEN + 1));
    check({tag, "_data"}, 64'(bus.write_data), 64'(e));
    check({tag, "_wreg"}, 64'(bus.write_reg), 64'(dest));
    check({tag, "_regwrite"}, 64'(bus.regwrite), 64'(dest != 5'd0));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic [31:0] exp, input string tag);
    @(negedge clock);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.dest_reg = dest;
    exp_q.push_back(exp);
    @(posedge clock); #1;
    scramble(1'b0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_result(tag, dest, 1'b0);
    @(posedge clock); #1;
    check({tag, "_drop"}, 64'({bus.done, bus.regwrite, bus.busy}), 64'd0);
    check({tag, "_hold"}, 64'(bus.write_data), 64'(exp));
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          pulses;
    bus.start = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0; bus.dest_reg = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_regwrite", 64'(bus.regwrite), 64'd0);
    check("rst_wreg", 64'(bus.write_reg), 64'd0);
    check("rst_wdata", 64'(bus.write_data), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clock); reset = 1'b0;

    run_op(3'b000, 32'd7, 32'd6, 5'd5, 32'd42, "mul_7x6");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, "mulhu_ones");
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, "mul_ones");
    run_op(3'b010, 32'd100, 32'd7, 5'd3, 32'd14, "divu_100_7");
    run_op(3'b011, 32'd100, 32'd7, 5'd4, 32'd2, "remu_100_7");
    run_op(3'b010, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, "divu_by0");
    run_op(3'b011, 32'd5, 32'd0, 5'd7, 32'd5, "remu_by0");
    run_op(3'b111, 32'd5, 32'd6, 5'd9, 32'd0, "rsvd");

    // start held high through a whole operation: only one result, re-accept after DONE.
    @(negedge clock);
    bus.start = 1'b1; bus.op = 3'b000; bus.operand_a = 32'd9; bus.operand_b = 32'd9; bus.dest_reg = 5'd3;
    exp_q.push_back(32'd81);
    @(posedge clock); #1;
    scramble(1'b1);
    wait_result("held_first", 5'd3, 1'b1);
    bus.op = 3'b010; bus.operand_a = 32'd1000; bus.operand_b = 32'd10; bus.dest_reg = 5'd4;
    exp_q.push_back(32'd100);
    @(posedge clock); #1;
    check("held_idle_gap", 64'({bus.busy, bus.done}), 64'd0);
    @(posedge clock); #1;
    check("held_reaccept", 64'(bus.busy), 64'd1);
    scramble(1'b0);
    wait_result("held_second", 5'd4, 1'b0);
    @(posedge clock); #1;

    run_op(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, "dest_x0");

    // Reset during CALC cycle 10 aborts without a write.
    @(negedge clock);
    bus.start = 1'b1; bus.op = 3'b000; bus.operand_a = 32'd5; bus.operand_b = 32'd5; bus.dest_reg = 5'd7;
    @(posedge clock); #1;
    scramble(1'b0);
    repeat (10) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("abort_outputs", 64'({bus.busy, bus.done, bus.regwrite}), 64'd0);
    check("abort_wreg", 64'(bus.write_reg), 64'd0);
    check("abort_wdata", 64'(bus.write_data), 64'd0);
    @(negedge clock); reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done || bus.regwrite) pulses++;
    end
    check("abort_no_write", 64'(pulses), 64'd0);

`ifdef MULDIV_SIGNED_EN
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, "div_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, "rem_m7_2");
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, "rem_ovf");
    run_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'd0, "mulh_m1_m1");
    run_op(3'b101, 32'hFFFF_FFF9, 32'd0, 5'd8, 32'hFFFF_FFFF, "div_by0");
`endif

    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 300));
        2:       b = 32'd0;
        default: begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
      endcase
      run_op(op, a, b, 5'($urandom), model(op, a, b), $sformatf("rand%0d_op%0d", i, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
